// File: rtl/gbs20_link_pkg.sv
// rtl/gbs20_link_pkg.sv - shared GBS20 link-test constants, PRBS7 definition and frame FSM states
package gbs20_link_pkg;

  localparam int DATA_WIDTH = 64;

  localparam int PRBS7_W = 7;
  localparam logic [PRBS7_W-1:0] PRBS7_SEED = 7'h7F;

  // Recurrence s[n] = s[n-PRBS7_TAP_A] ^ s[n-PRBS7_TAP_B] for x^7 + x^6 + 1
  localparam int PRBS7_TAP_A = 7;
  localparam int PRBS7_TAP_B = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/prbs7_par_gen.sv
// rtl/prbs7_par_gen.sv - combinational PRBS7 stepper: 7-bit state to one 64-bit frame plus next state
module prbs7_par_gen
  import gbs20_link_pkg::*;
(
  input  logic [PRBS7_W-1:0]    state,
  output logic [DATA_WIDTH-1:0] frame,
  output logic [PRBS7_W-1:0]    nextState
);

  localparam int SEQ_W = DATA_WIDTH + PRBS7_W;

  // state[j] holds serial bit s[n+j]; seq extends it to s[n .. n+70]
  logic [SEQ_W-1:0] seq;

  // Unroll the serial recurrence 64 steps past the current state
  always_comb begin
    seq = '0;
    seq[PRBS7_W-1:0] = state;
    for (int n = PRBS7_W; n < SEQ_W; n++) begin
      seq[n] = seq[n-PRBS7_TAP_A] ^ seq[n-PRBS7_TAP_B];
    end
  end

  assign frame     = seq[DATA_WIDTH-1:0];
  assign nextState = seq[SEQ_W-1:DATA_WIDTH];

endmodule

// File: rtl/prbs7_frame_gen.sv
// rtl/prbs7_frame_gen.sv - PRBS7 64-bit frame source with bit-slip; error injection built only with ERR_INJECT_EN
module prbs7_frame_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int PERIOD_W   = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  slip_load,
  input  logic [5:0]            slip_offset,
  input  logic                  err_inject,
  input  logic [PERIOD_W-1:0]   inj_period,
  input  logic [DATA_WIDTH-1:0] inj_mask,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [CNT_W-1:0]      inj_count,
  output logic [31:0]           frame_count
);

  import gbs20_link_pkg::*;

  localparam int BUF_W = 2 * DATA_WIDTH;

  state_t                state;
  logic [PRBS7_W-1:0]    prbsState;
  logic [PRBS7_W-1:0]    prbsNext;
  logic [DATA_WIDTH-1:0] genFrame;
  logic [BUF_W-1:0]      frameBuf;
  logic                  bufFull;
  logic [5:0]            slipReg;
  logic [DATA_WIDTH-1:0] rawWindow;
  logic [DATA_WIDTH-1:0] injXor;

  prbs7_par_gen uGen (
    .state     (prbsState),
    .frame     (genFrame),
    .nextState (prbsNext)
  );

  // Slipped window: raw[i] = buf[slip + i], spanning the older and newer buffered frames
  always_comb begin
    rawWindow = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      rawWindow[i] = frameBuf[{1'b0, slipReg} + 7'(i)];
    end
  end

`ifdef ERR_INJECT_EN
  logic                injPending;
  logic [PERIOD_W-1:0] periodCnt;
  logic [CNT_W-1:0]    injCountReg;
  logic                frameEmit;
  logic                periodHit;
  logic                injHit;

  assign frameEmit = enable && (state == RUN) && bufFull;
  assign periodHit = (inj_period != '0) && (periodCnt == inj_period - PERIOD_W'(1));
  // Single-shot and periodic hits on the same frame collapse into one injection
  assign injHit    = frameEmit && (injPending || periodHit);
  assign injXor    = injHit ? inj_mask : '0;
  assign inj_count = injCountReg;

  // Pending single-shot (armed by a pulse, consumed by the next emitted frame), period counter, saturating count
  always_ff @(posedge clk) begin
    if (reset) begin
      injPending  <= 1'b0;
      periodCnt   <= '0;
      injCountReg <= '0;
    end else begin
      injPending <= err_inject || (injPending && !frameEmit);
      if (inj_period == '0) begin
        periodCnt <= '0;
      end else if (frameEmit) begin
        periodCnt <= periodHit ? '0 : periodCnt + PERIOD_W'(1);
      end
      if (injHit && (injCountReg != '1)) begin
        injCountReg <= injCountReg + CNT_W'(1);
      end
    end
  end
`else
  logic unusedInj;
  assign unusedInj = ^{err_inject, inj_period, inj_mask};
  assign injXor    = '0;
  assign inj_count = '0;
`endif

  // Frame FSM: PRIME loads frame 0, RUN shifts in one frame per clock and emits the slipped window
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      prbsState   <= PRBS7_SEED;
      frameBuf    <= '0;
      bufFull     <= 1'b0;
      slipReg     <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      frame_count <= '0;
    end else begin
      if (slip_load) begin
        slipReg <= slip_offset;
      end
      if (!enable) begin
        state      <= IDLE;
        prbsState  <= PRBS7_SEED;
        frameBuf   <= '0;
        bufFull    <= 1'b0;
        dout       <= '0;
        dout_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state      <= PRIME;
            dout       <= '0;
            dout_valid <= 1'b0;
          end
          PRIME: begin
            state     <= RUN;
            prbsState <= prbsNext;
            frameBuf  <= {genFrame, frameBuf[BUF_W-1:DATA_WIDTH]};
          end
          RUN: begin
            prbsState <= prbsNext;
            frameBuf  <= {genFrame, frameBuf[BUF_W-1:DATA_WIDTH]};
            bufFull   <= 1'b1;
            // The window is only meaningful once both buffer halves hold stream data
            if (bufFull) begin
              dout        <= rawWindow ^ injXor;
              dout_valid  <= 1'b1;
              frame_count <= frame_count + 32'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs7_frame_gen.sv
// tb/tb_prbs7_frame_gen.sv - self-checking bench for prbs7_frame_gen against a serial PRBS7 reference
module tb_prbs7_frame_gen;

  localparam int PERIOD_W = 16;
  localparam int CNT_W    = 16;
  localparam int SEQ_LEN  = 64 * 1100 + 128;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic                slip_load;
  logic [5:0]          slip_offset;
  logic                err_inject;
  logic [PERIOD_W-1:0] inj_period;
  logic [63:0]         inj_mask;
  logic [63:0]         dout;
  logic                dout_valid;
  logic [CNT_W-1:0]    inj_count;
  logic [31:0]         frame_count;

  int compared   = 0;
  int mismatched = 0;
  bit injEnabled;
  bit prbsSeq [SEQ_LEN];

  always #5 clk = ~clk;

  prbs7_frame_gen #(
    .DATA_WIDTH (64),
    .PERIOD_W   (PERIOD_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .slip_load   (slip_load),
    .slip_offset (slip_offset),
    .err_inject  (err_inject),
    .inj_period  (inj_period),
    .inj_mask    (inj_mask),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .inj_count   (inj_count),
    .frame_count (frame_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] refFrame(input int k, input int off);
    logic [63:0] f;
    for (int i = 0; i < 64; i++) f[i] = prbsSeq[64*k + off + i];
    return f;
  endfunction

  function automatic bit isCorrupt(input int k, input int period, input int shot);
    if (!injEnabled) return 1'b0;
    return ((period != 0) && (((k + 1) % period) == 0)) || (k == shot);
  endfunction

  task automatic fresh_start(input int slip);
    reset = 1'b1; enable = 1'b0; err_inject = 1'b0; slip_load = 1'b0;
    tick();
    reset = 1'b0;
    slip_offset = 6'(slip);
    slip_load = 1'b1;
    tick();
    slip_load = 1'b0;
  endtask

  // shot: frame index hit by a single-shot (-1 none); chg: frame at whose edge newSlip is loaded (-1 none)
  task automatic expect_stream(input string name, input int n, input int slip, input int newSlip,
                               input int chg, input int period, input logic [63:0] mask,
                               input int shot, input int fcBase);
    int          offset;
    int          injExp;
    logic [63:0] expFrame;
    injExp     = 0;
    inj_period = PERIOD_W'(period);
    inj_mask   = mask;
    err_inject = (shot == 0);
    enable     = 1'b1;
    tick();
    err_inject = 1'b0;
    compared++;
    if (dout_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL %s latency_E: dout_valid=%0b expected 0", name, dout_valid);
    end
    tick();
    tick();
    compared++;
    if (dout_valid !== 1'b0 || dout !== 64'h0) begin
      mismatched++;
      $display("FAIL %s latency_E2: dout_valid=%0b dout=%h expected 0/0", name, dout_valid, dout);
    end
    for (int j = 0; j < n; j++) begin
      err_inject = (j + 1 == shot);
      if (j == chg) begin
        slip_offset = 6'(newSlip);
        slip_load   = 1'b1;
      end
      tick();
      err_inject = 1'b0;
      slip_load  = 1'b0;
      offset   = (chg >= 0 && j > chg) ? newSlip : slip;
      expFrame = refFrame(j, offset);
      if (isCorrupt(j, period, shot)) begin
        expFrame = expFrame ^ mask;
        injExp++;
      end
      compared++;
      if (dout_valid !== 1'b1 || dout !== expFrame) begin
        mismatched++;
        $display("FAIL %s frame%0d: valid=%0b dout=%h expected valid=1 dout=%h", name, j, dout_valid, dout, expFrame);
      end
      compared++;
      if (frame_count !== 32'(fcBase + j + 1)) begin
        mismatched++;
        $display("FAIL %s frame_count@%0d: got %0d expected %0d", name, j, frame_count, fcBase + j + 1);
      end
    end
    compared++;
    if (inj_count !== CNT_W'(injExp)) begin
      mismatched++;
      $display("FAIL %s inj_count: got %0d expected %0d", name, inj_count, injExp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; err_inject = 1'b1; slip_load = 1'b1;
    slip_offset = 6'd9; inj_period = 16'd1; inj_mask = '1;
    tick();
    compared++;
    if (dout !== 64'h0 || dout_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: dout=%h valid=%0b expected 0/0", dout, dout_valid);
    end
    compared++;
    if (frame_count !== 32'd0 || inj_count !== '0) begin
      mismatched++;
      $display("FAIL reset_counters: frame_count=%0d inj_count=%0d expected 0/0", frame_count, inj_count);
    end
    err_inject = 1'b0; slip_load = 1'b0; enable = 1'b0;
  endtask

  task automatic test_stream();
    fresh_start(0);
    expect_stream("stream", 1000, 0, 0, -1, 0, 64'h0, -1, 0);
  endtask

  task automatic test_slip();
    int found;
    fresh_start(13);
    expect_stream("slip13", 200, 13, 13, -1, 0, 64'h0, -1, 0);
    found = -1;
    for (int o = 0; o < 64; o++) if (found < 0 && dout === refFrame(199, o)) found = o;
    compared++;
    if (found != 13) begin
      mismatched++;
      $display("FAIL slip_align: receiver locked at offset %0d expected 13", found);
    end
  endtask

  task automatic test_periodic();
    fresh_start(0);
    expect_stream("periodic", 300, 0, 0, -1, 100, 64'h1, -1, 0);
  endtask

  task automatic test_shot_on_period();
    fresh_start(0);
    expect_stream("shot_on_period", 150, 0, 0, -1, 100, 64'hFF00, 99, 0);
  endtask

  task automatic test_random();
    int          slip, newSlip, chg, period, shot;
    logic [63:0] mask;
    for (int it = 0; it < 4; it++) begin
      slip    = int'($urandom_range(0, 63));
      newSlip = int'($urandom_range(0, 63));
      chg     = int'($urandom_range(10, 100));
      period  = (it == 0) ? 1 : int'($urandom_range(0, 40));
      mask    = (it == 0) ? 64'h0 : {$urandom, $urandom};
      shot    = int'($urandom_range(0, 119));
      fresh_start(slip);
      expect_stream($sformatf("random%0d", it), 120, slip, newSlip, chg, period, mask, shot, 0);
    end
  endtask

  task automatic test_midrun_reset();
    fresh_start(0);
    expect_stream("midrun_pre", 30, 0, 0, -1, 7, {$urandom, $urandom}, 12, 0);
    reset = 1'b1;
    tick();
    compared++;
    if (dout !== 64'h0 || dout_valid !== 1'b0 || frame_count !== 32'd0 || inj_count !== '0) begin
      mismatched++;
      $display("FAIL midrun_reset: dout=%h valid=%0b frame_count=%0d inj_count=%0d expected all 0",
               dout, dout_valid, frame_count, inj_count);
    end
    reset = 1'b0;
    expect_stream("midrun_post", 20, 0, 0, -1, 0, 64'h0, -1, 0);
  endtask

  task automatic test_idle_return();
    fresh_start(5);
    expect_stream("idle_pre", 10, 5, 5, -1, 0, 64'h0, -1, 0);
    enable = 1'b0;
    tick();
    compared++;
    if (dout !== 64'h0 || dout_valid !== 1'b0 || frame_count !== 32'd10) begin
      mismatched++;
      $display("FAIL idle_return: dout=%h valid=%0b frame_count=%0d expected 0/0/10", dout, dout_valid, frame_count);
    end
    expect_stream("idle_post", 10, 5, 5, -1, 0, 64'h0, -1, 10);
  endtask

  initial begin
`ifdef ERR_INJECT_EN
    injEnabled = 1'b1;
`else
    injEnabled = 1'b0;
`endif
    for (int n = 0; n < SEQ_LEN; n++) prbsSeq[n] = (n < 7) ? 1'b1 : (prbsSeq[n-7] ^ prbsSeq[n-6]);
    reset = 1'b1; enable = 1'b0; slip_load = 1'b0; slip_offset = '0;
    err_inject = 1'b0; inj_period = '0; inj_mask = '0;
    test_reset();
    test_stream();
    test_slip();
    test_periodic();
    test_shot_on_period();
    test_random();
    test_midrun_reset();
    test_idle_return();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
